// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state encoding and default vectors for the fetch PC generator
package pc_pkg;

   // Fetch FSM states: BOOT holds the reset vector for one cycle, RUN fetches
   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Default vectors and step used when the top is not overridden
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0100;
   localparam int          DEF_STEP      = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - one-entry buffer for a redirect that arrives during a stall
module pc_redirect_buf
   import pc_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [ADDR_W-1:0] new_target,
   output logic              pend,
   output logic [ADDR_W-1:0] target
);

   // Clear wins over load; a load while already pending overwrites the older target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend   <= 1'b0;
         target <= '0;
      end else if (clear) begin
         pend   <= 1'b0;
      end else if (load) begin
         pend   <= 1'b1;
         target <= new_target;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with stall hold, redirect buffer and trap
module pc_gen
   import pc_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = DEF_RESET_VEC,
   parameter logic [ADDR_W-1:0] EXC_VEC    = DEF_EXC_VEC,
   parameter int                STEP       = DEF_STEP,
   parameter int                ALIGN_BITS = 2,
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              redir_i,
   input  logic [ADDR_W-1:0] redir_pc_i,
   input  logic              exc_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              fetch_valid_o,
   output logic              pend_o,
   output logic              fault_o,
   output logic [ADDR_W-1:0] bad_pc_o,
   output logic [CNT_W-1:0]  adv_cnt_o
);

   // Mask of low bits that must be zero; an all-zero mask disables the check
   localparam logic [ADDR_W-1:0] ONE_W      = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ALIGN_MASK = (ONE_W << ALIGN_BITS) - ONE_W;
   localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(STEP);
   localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [0:0]        state;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              pc_load;
   logic              fault_q;
   logic              fault_d;
   logic [ADDR_W-1:0] bad_pc_q;
   logic [ADDR_W-1:0] bad_pc_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              misaligned;
   logic              buf_load;
   logic              buf_clear;
   logic              buf_pend;
   logic [ADDR_W-1:0] buf_target;

   assign misaligned = |(redir_pc_i & ALIGN_MASK);

   pc_redirect_buf #(
      .ADDR_W (ADDR_W)
   ) u_redirect_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (buf_load),
      .clear      (buf_clear),
      .new_target (redir_pc_i),
      .pend       (buf_pend),
      .target     (buf_target)
   );

   // Next-PC selection in RUN: exception, trap, redirect, buffered redirect, stall, step
   always_comb begin
      pc_d      = pc_q;
      pc_load   = 1'b0;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      fault_d   = 1'b0;
      bad_pc_d  = bad_pc_q;
      if (state == ST_RUN) begin
         if (exc_i) begin
            pc_d      = EXC_VEC;
            pc_load   = 1'b1;
            buf_clear = 1'b1;
         end else if (redir_i && misaligned) begin
            pc_d      = EXC_VEC;
            pc_load   = 1'b1;
            buf_clear = 1'b1;
            fault_d   = 1'b1;
            bad_pc_d  = redir_pc_i;
         end else if (redir_i && !stall_i) begin
            pc_d      = redir_pc_i;
            pc_load   = 1'b1;
            buf_clear = 1'b1;
         end else if (redir_i) begin
            buf_load  = 1'b1;
         end else if (buf_pend && !stall_i) begin
            pc_d      = buf_target;
            pc_load   = 1'b1;
            buf_clear = 1'b1;
         end else if (!stall_i) begin
            pc_d      = pc_q + STEP_W;
            pc_load   = 1'b1;
         end
      end
   end

   // State, PC, trap record and advance counter; BOOT leaves everything but state untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_BOOT;
         pc_q     <= RESET_VEC;
         fault_q  <= 1'b0;
         bad_pc_q <= '0;
         cnt_q    <= '0;
      end else begin
         state    <= ST_RUN;
         pc_q     <= pc_d;
         fault_q  <= fault_d;
         bad_pc_q <= bad_pc_d;
         if (pc_load) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   assign pc_o          = pc_q;
   assign fetch_valid_o = (state == ST_RUN);
   assign pend_o        = buf_pend;
   assign fault_o       = fault_q;
   assign bad_pc_o      = bad_pc_q;
   assign adv_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed self-checking bench for pc_gen
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redir_i;
   logic [31:0] redir_pc_i;
   logic        exc_i;
   logic [31:0] pc_o;
   logic        fetch_valid_o;
   logic        pend_o;
   logic        fault_o;
   logic [31:0] bad_pc_o;
   logic [15:0] adv_cnt_o;

   int checks;
   int errors;

   // Reference model state, described in terms of observable behaviour
   logic        m_run;
   logic [31:0] m_pc;
   logic        m_pend;
   logic [31:0] m_tgt;
   logic        m_fault;
   logic [31:0] m_bad;
   logic [15:0] m_cnt;

   pc_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redir_i       (redir_i),
      .redir_pc_i    (redir_pc_i),
      .exc_i         (exc_i),
      .pc_o          (pc_o),
      .fetch_valid_o (fetch_valid_o),
      .pend_o        (pend_o),
      .fault_o       (fault_o),
      .bad_pc_o      (bad_pc_o),
      .adv_cnt_o     (adv_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_run   = 1'b0;
      m_pc    = 32'h0;
      m_pend  = 1'b0;
      m_tgt   = 32'h0;
      m_fault = 1'b0;
      m_bad   = 32'h0;
      m_cnt   = 16'h0;
   endtask

   // One clock of the reference: the priority list applied to the inputs seen at the edge
   task automatic model_step();
      bit odd_target;
      odd_target = (redir_pc_i % 4) != 0;
      m_fault = 1'b0;
      if (!m_run) begin
         m_run = 1'b1;
      end else if (exc_i) begin
         m_pc = 32'h100; m_pend = 1'b0; m_cnt++;
      end else if (redir_i && odd_target) begin
         m_pc = 32'h100; m_pend = 1'b0; m_fault = 1'b1; m_bad = redir_pc_i; m_cnt++;
      end else if (redir_i && !stall_i) begin
         m_pc = redir_pc_i; m_pend = 1'b0; m_cnt++;
      end else if (redir_i) begin
         m_pend = 1'b1; m_tgt = redir_pc_i;
      end else if (m_pend && !stall_i) begin
         m_pc = m_tgt; m_pend = 1'b0; m_cnt++;
      end else if (!stall_i) begin
         m_pc = m_pc + 32'd4; m_cnt++;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, leave outputs settled
   task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic e);
      stall_i    = s;
      redir_i    = r;
      redir_pc_i = rp;
      exc_i      = e;
      @(posedge clk);
      model_step();
      #1;
      stall_i = 1'b0;
      redir_i = 1'b0;
      exc_i   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall_i = 1'b0; redir_i = 1'b0; redir_pc_i = 32'h0; exc_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h0); end
      checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fetch_valid_o); end
      checks++; if (pend_o !== 1'b0 || fault_o !== 1'b0) begin errors++; $display("FAIL reset_flags got pend %b fault %b want 0 0", pend_o, fault_o); end
      checks++; if (bad_pc_o !== 32'h0 || adv_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_regs got bad %h cnt %0d want 0 0", bad_pc_o, adv_cnt_o); end
      rst_n = 1'b1;
   endtask

   task automatic test_boot_sequence();
      logic [31:0] want_pc [3] = '{32'h0, 32'h4, 32'h8};
      checks++; if (pc_o !== 32'h0 || fetch_valid_o !== 1'b0) begin errors++; $display("FAIL boot_state got pc %h valid %b want 0 0", pc_o, fetch_valid_o); end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         checks++; if (pc_o !== want_pc[i] || fetch_valid_o !== 1'b1) begin errors++; $display("FAIL boot_seq%0d got pc %h valid %b want %h 1", i, pc_o, fetch_valid_o, want_pc[i]); end
      end
      checks++; if (adv_cnt_o !== 16'd2) begin errors++; $display("FAIL boot_cnt got %0d want 2", adv_cnt_o); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0);
         checks++; if (pc_o !== 32'h8) begin errors++; $display("FAIL stall_hold%0d got %h want %h", i, pc_o, 32'h8); end
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (pc_o !== 32'hC) begin errors++; $display("FAIL stall_release got %h want %h", pc_o, 32'hC); end
      checks++; if (adv_cnt_o !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", adv_cnt_o); end
   endtask

   task automatic test_pending_redirect();
      step(1'b1, 1'b1, 32'h40, 1'b0);
      checks++; if (pc_o !== 32'hC || pend_o !== 1'b1) begin errors++; $display("FAIL pend_first got pc %h pend %b want %h 1", pc_o, pend_o, 32'hC); end
      step(1'b1, 1'b1, 32'h80, 1'b0);
      checks++; if (pc_o !== 32'hC || pend_o !== 1'b1) begin errors++; $display("FAIL pend_second got pc %h pend %b want %h 1", pc_o, pend_o, 32'hC); end
      step(1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (pc_o !== 32'hC || pend_o !== 1'b1) begin errors++; $display("FAIL pend_hold got pc %h pend %b want %h 1", pc_o, pend_o, 32'hC); end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (pc_o !== 32'h80 || pend_o !== 1'b0) begin errors++; $display("FAIL pend_release got pc %h pend %b want %h 0", pc_o, pend_o, 32'h80); end
   endtask

   task automatic test_exception();
      step(1'b1, 1'b1, 32'h200, 1'b0);
      checks++; if (pend_o !== 1'b1) begin errors++; $display("FAIL exc_setup got pend %b want 1", pend_o); end
      step(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (pc_o !== 32'h100 || pend_o !== 1'b0) begin errors++; $display("FAIL exc_redirect got pc %h pend %b want %h 0", pc_o, pend_o, 32'h100); end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (pc_o !== 32'h104) begin errors++; $display("FAIL exc_after got %h want %h", pc_o, 32'h104); end
   endtask

   task automatic test_misaligned();
      step(1'b0, 1'b1, 32'h42, 1'b0);
      checks++; if (pc_o !== 32'h100 || fault_o !== 1'b1 || bad_pc_o !== 32'h42) begin errors++; $display("FAIL trap got pc %h fault %b bad %h want %h 1 %h", pc_o, fault_o, bad_pc_o, 32'h100, 32'h42); end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (fault_o !== 1'b0 || bad_pc_o !== 32'h42 || pc_o !== 32'h104) begin errors++; $display("FAIL trap_after got pc %h fault %b bad %h want %h 0 %h", pc_o, fault_o, bad_pc_o, 32'h104, 32'h42); end
      step(1'b1, 1'b1, 32'h1003, 1'b0);
      checks++; if (pc_o !== 32'h100 || fault_o !== 1'b1 || pend_o !== 1'b0 || bad_pc_o !== 32'h1003) begin errors++; $display("FAIL trap_stalled got pc %h fault %b pend %b bad %h want %h 1 0 %h", pc_o, fault_o, pend_o, bad_pc_o, 32'h100, 32'h1003); end
   endtask

   task automatic test_async_reset();
      step(1'b1, 1'b1, 32'h40, 1'b0);
      stall_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (pc_o !== 32'h0 || pend_o !== 1'b0 || adv_cnt_o !== 16'h0 || fetch_valid_o !== 1'b0) begin errors++; $display("FAIL async_reset got pc %h pend %b cnt %0d valid %b want 0 0 0 0", pc_o, pend_o, adv_cnt_o, fetch_valid_o); end
      @(negedge clk);
      stall_i = 1'b0;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (pc_o !== 32'h4 || pend_o !== 1'b0) begin errors++; $display("FAIL reset_discard got pc %h pend %b want %h 0", pc_o, pend_o, 32'h4); end
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load got %h want %h", pc_o, 32'hFFFF_FFFC); end
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_step got %h want %h", pc_o, 32'h0); end
      checks++; if (adv_cnt_o !== m_cnt) begin errors++; $display("FAIL wrap_cnt got %0d want %0d", adv_cnt_o, m_cnt); end
   endtask

   task automatic test_random();
      logic        s, r, e;
      logic [31:0] rp;
      for (int i = 0; i < 400; i++) begin
         s  = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 4) == 0);
         e  = ($urandom_range(0, 15) == 0);
         rp = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) rp = rp | 32'($urandom_range(1, 3));
         step(s, r, rp, e);
         checks++;
         if (pc_o !== m_pc || pend_o !== m_pend || fault_o !== m_fault || bad_pc_o !== m_bad || adv_cnt_o !== m_cnt || fetch_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL random%0d got pc %h pend %b fault %b bad %h cnt %0d valid %b want %h %b %b %h %0d 1",
                     i, pc_o, pend_o, fault_o, bad_pc_o, adv_cnt_o, fetch_valid_o, m_pc, m_pend, m_fault, m_bad, m_cnt);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      @(negedge clk);
      test_boot_sequence();
      test_stall();
      test_pending_redirect();
      test_exception();
      test_misaligned();
      test_async_reset();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
